// File: rtl/hopfield_pkg.sv
// hopfield_pkg: shared constants, types and weight saturation for the Hebbian trainer.
package hopfield_pkg;
  localparam int N = 25;
  localparam int W = 4;
  localparam int P_MAX = 4;
  localparam int AW = $clog2(N * N);
  localparam int KW = $clog2(N);
  localparam int W_MAX = 2 ** (W - 1) - 1;
  localparam int W_MIN = -(2 ** (W - 1));
  typedef logic signed [W-1:0] weight_t;
  typedef logic [N-1:0] pattern_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  function automatic weight_t sat_w(input int s);
    return s > W_MAX ? weight_t'(W_MAX) : s < W_MIN ? weight_t'(W_MIN) : weight_t'(s);
  endfunction
endpackage

// File: rtl/hebb_pair_sum.sv
// hebb_pair_sum: +1/-1 agreement sum of bits k and m over the stored patterns, saturated.
// ZERO_DIAG_EN: when defined, the self-link (k==m) weight is forced to zero.
module hebb_pair_sum import hopfield_pkg::*; #(
  parameter int PM = hopfield_pkg::P_MAX,
  localparam int CW = $clog2(PM + 1),
  localparam int SW = CW + 1
) (
  input  pattern_t      slots_i [PM],
  input  logic [CW-1:0] count_i,
  input  logic [KW-1:0] k_i,
  input  logic [KW-1:0] m_i,
  output weight_t       weight_o
);
  localparam logic signed [SW-1:0] ONE = SW'(1);
  logic signed [SW-1:0] acc;
  always_comb begin
    acc = '0;
    for (int i = 0; i < PM; i++)
      if (i < int'(count_i)) acc += (slots_i[i][k_i] == slots_i[i][m_i]) ? ONE : -ONE;
  end
`ifdef ZERO_DIAG_EN
  assign weight_o = (k_i == m_i) ? '0 : sat_w(int'(acc));
`else
  assign weight_o = sat_w(int'(acc));
`endif
endmodule

// File: rtl/hebb_trainer.sv
// hebb_trainer: stores up to P_MAX binary patterns and streams the N*N Hebbian weights, one per clock.
// ZERO_DIAG_EN (handled in hebb_pair_sum) zeroes the diagonal weights without changing stream timing.
module hebb_trainer import hopfield_pkg::*; #(
  parameter int P_MAX = hopfield_pkg::P_MAX,
  localparam int CW = $clog2(P_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  pattern_t      pat_data,
  input  logic          pat_valid,
  output logic          pat_ready,
  input  logic          clear,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pat_count,
  output logic          w_we,
  output logic [AW-1:0] w_addr,
  output weight_t       w_data
);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d, m_q, m_d;
  logic we_q, we_d, done_q, done_d;
  logic [AW-1:0] addr_q, addr_d;
  weight_t data_q, data_d, pair_w;
  pattern_t slots_q [P_MAX];
  logic accept, last_m;
  hebb_pair_sum #(.PM(P_MAX)) u_sum (
    .slots_i  (slots_q),
    .count_i  (cnt_q),
    .k_i      (k_q),
    .m_i      (m_q),
    .weight_o (pair_w)
  );
  assign pat_ready = state_q == IDLE && cnt_q < CW'(P_MAX) && !start && !clear;
  assign accept = pat_valid && pat_ready;
  assign last_m = m_q == KW'(N - 1);
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign pat_count = cnt_q;
  assign w_we = we_q;
  assign w_addr = addr_q;
  assign w_data = data_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    k_d = k_q;
    m_d = m_q;
    we_d = 1'b0;
    done_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        cnt_d = clear ? '0 : cnt_q + CW'(accept);
        state_d = start && !clear ? RUN : IDLE;
        k_d = '0;
        m_d = '0;
      end
      RUN: begin
        we_d = 1'b1;
        addr_d = AW'(k_q) * AW'(N) + AW'(m_q);
        data_d = pair_w;
        m_d = last_m ? '0 : m_q + KW'(1);
        k_d = k_q + KW'(last_m);
        state_d = last_m && k_q == KW'(N - 1) ? FLUSH : RUN;
      end
      default: begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k_q <= '0;
      m_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      m_q <= m_d;
      we_q <= we_d;
      done_q <= done_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  // Slot contents need no reset: only the first pat_count entries are ever summed.
  always_ff @(posedge clk)
    if (accept) slots_q[cnt_q] <= pat_data;
endmodule

// File: tb/tb_hebb_trainer.sv
// tb_hebb_trainer: drives a P_MAX=4 and a P_MAX=10 trainer with identical stimulus and checks both
// against an integer Hebbian model of their stored patterns.
module tb_hebb_trainer;
  logic clk = 0, rst = 0;
  logic [24:0] pat_data = '0;
  logic pat_valid = 0, clear = 0, start = 0;
  logic rdy [2], busy [2], done [2], we [2];
  logic [9:0] addr [2];
  logic signed [3:0] wd [2];
  logic [2:0] cnt4;
  logic [3:0] cnt10;
  int checks = 0, failures = 0;
  logic [24:0] ms [2][10];
  int mc [2] = '{0, 0};
  int pmax [2] = '{4, 10};
  int w01 [2][2];
`ifdef ZERO_DIAG_EN
  localparam int D4 = 0;
`else
  localparam int D4 = 4;
`endif
  always #5 clk = ~clk;
  hebb_trainer dut4 (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(rdy[0]),
    .clear(clear), .start(start), .busy(busy[0]), .done(done[0]), .pat_count(cnt4),
    .w_we(we[0]), .w_addr(addr[0]), .w_data(wd[0])
  );
  hebb_trainer #(.P_MAX(10)) dut10 (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(rdy[1]),
    .clear(clear), .start(start), .busy(busy[1]), .done(done[1]), .pat_count(cnt10),
    .w_we(we[1]), .w_addr(addr[1]), .w_data(wd[1])
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic int cnt_of(input int d);
    return d == 0 ? int'(cnt4) : int'(cnt10);
  endfunction
  function automatic int exp_w(input int d, input int k, input int m);
    int s = 0;
`ifdef ZERO_DIAG_EN
    if (k == m) return 0;
`endif
    for (int i = 0; i < mc[d]; i++) s += (ms[d][i][k] == ms[d][i][m]) ? 1 : -1;
    return s > 7 ? 7 : (s < -8 ? -8 : s);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 0; start = 0; clear = 0; pat_valid = 0;
    tick;
    rst = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst_busy", d), busy[d], 0);
      check($sformatf("d%0d rst_done", d), done[d], 0);
      check($sformatf("d%0d rst_we", d), we[d], 0);
      check($sformatf("d%0d rst_addr", d), addr[d], 0);
      check($sformatf("d%0d rst_data", d), wd[d], 0);
      check($sformatf("d%0d rst_cnt", d), cnt_of(d), 0);
      mc[d] = 0;
    end
  endtask
  task automatic push(input logic [24:0] p);
    pat_data = p; pat_valid = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rdy", d), rdy[d], int'(mc[d] < pmax[d]));
      if (mc[d] < pmax[d]) begin
        ms[d][mc[d]] = p;
        mc[d]++;
      end
    end
    tick;
    pat_valid = 0;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d cnt", d), cnt_of(d), mc[d]);
  endtask
  task automatic clr(input logic with_start);
    clear = 1; start = with_start;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d rdy_clear", d), rdy[d], 0);
    tick;
    clear = 0; start = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d cnt_clear", d), cnt_of(d), 0);
      check($sformatf("d%0d busy_clear", d), busy[d], 0);
      mc[d] = 0;
    end
    repeat (3) begin
      tick;
      for (int d = 0; d < 2; d++) check($sformatf("d%0d no_write", d), we[d], 0);
    end
  endtask
  task automatic run(input logic hold);
    int n [2], nd [2], dc [2];
    pat_valid = hold; pat_data = 25'h15A5A5A; start = 1;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d rdy_start", d), rdy[d], 0);
    tick;
    start = 0;
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; nd[d] = 0; dc[d] = 0;
    end
    for (int c = 1; c <= 630; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        if (hold && c <= 626) check($sformatf("d%0d rdy_run", d), rdy[d], 0);
        if (c == 1 || c == 626) check($sformatf("d%0d busy_run", d), busy[d], 1);
        if (c == 627) check($sformatf("d%0d busy_done", d), busy[d], 0);
        if (we[d]) begin
          check($sformatf("d%0d addr", d), addr[d], n[d]);
          check($sformatf("d%0d data@%0d", d, n[d]), wd[d], exp_w(d, n[d] / 25, n[d] % 25));
          if (n[d] < 2) w01[d][n[d]] = int'(wd[d]);
          n[d]++;
        end
        if (done[d]) begin
          nd[d]++;
          dc[d] = c;
        end
      end
      if (c == 626) pat_valid = 0;
      tick;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d writes", d), n[d], 625);
      check($sformatf("d%0d done_count", d), nd[d], 1);
      check($sformatf("d%0d done_cycle", d), dc[d], 627);
      check($sformatf("d%0d cnt_kept", d), cnt_of(d), mc[d]);
    end
  endtask
  initial begin
    do_reset;
    run(0);
    push(25'b0111010010100101001001111);
    push(25'b0011101001010000100011111);
    push(25'b1111000001000010000111110);
    push(25'b1000110001101011101110001);
    #1;
    check("d0 rdy_full", rdy[0], 0);
    check("d1 rdy_room", rdy[1], 1);
    run(1);
    check("d0 w_addr0", w01[0][0], D4);
    check("d0 w_addr1", w01[0][1], 0);
    push(25'h00F0F0F);
    start = 1;
    tick;
    start = 0;
    repeat (300) tick;
    rst = 0;
    tick;
    rst = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d abort_we", d), we[d], 0);
      check($sformatf("d%0d abort_busy", d), busy[d], 0);
      check($sformatf("d%0d abort_cnt", d), cnt_of(d), 0);
      mc[d] = 0;
    end
    repeat (5) begin
      tick;
      for (int d = 0; d < 2; d++) check($sformatf("d%0d abort_done", d), done[d], 0);
    end
    for (int r = 0; r < 2; r++) begin
      int np = int'($urandom_range(1, 10));
      for (int i = 0; i < np; i++) begin
        logic [24:0] p = 25'($urandom);
        push(p);
      end
      run(0);
      clr(0);
    end
    push(25'($urandom));
    push(25'($urandom));
    clr(1);
    repeat (10) push(25'h1FFFFFF);
    run(0);
    check("d1 sat_addr1", w01[1][1], 7);
    check("d0 full_addr1", w01[0][1], 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
